// File: rtl/carpark_sensor_gen_if.sv
// carpark_sensor_gen_if: beam-sensor bus between the stimulus generator (master) and the car-park FSM (slave).
// The abort line exists only when CARPARK_GEN_ABORT_EN is defined.
interface carpark_sensor_gen_if #(parameter int CNT_W = 8);
   logic start, dir, a, b, busy, done;
   logic [CNT_W-1:0] cars_in, cars_out;
`ifdef CARPARK_GEN_ABORT_EN
   logic abort;
   modport master (input start, dir, abort, output a, b, busy, done, cars_in, cars_out);
   modport slave (output start, dir, abort, input a, b, busy, done, cars_in, cars_out);
`else
   modport master (input start, dir, output a, b, busy, done, cars_in, cars_out);
   modport slave (output start, dir, input a, b, busy, done, cars_in, cars_out);
`endif
endinterface

// File: rtl/carpark_sensor_gen.sv
// carpark_sensor_gen: emits the a/b beam occlusion sequence for one car entering or exiting and counts completed cars.
// Optional car back-out (abort) support is enabled by defining CARPARK_GEN_ABORT_EN.
module carpark_sensor_gen #(
   parameter int DWELL = 4,
   parameter int CNT_W = 8
) (
   input logic clk,
   input logic reset,
   carpark_sensor_gen_if.master bus
);
   typedef enum logic [2:0] {IDLE, P1, P2, P3, R1, DONE} state_t;
   state_t state, nxt;
   logic [7:0] cnt;
   logic dir_l, aborted, abrt, take_abort, d, inc;
   logic [1:0] pat;
   logic [CNT_W-1:0] cin, cout;
`ifdef CARPARK_GEN_ABORT_EN
   assign abrt = bus.abort;
`else
   assign abrt = 1'b0;
`endif
   // Outputs are registered from the next state, so they change together with the state.
   always_comb begin
      take_abort = abrt && (state == P1 || state == P2);
      nxt = state == IDLE ? (bus.start ? P1 : IDLE) :
            state == DONE ? IDLE :
            take_abort ? (state == P1 ? DONE : R1) :
            cnt != 8'd0 ? state :
            state == P1 ? P2 : state == P2 ? P3 : DONE;
      d = state == IDLE ? bus.dir : dir_l;
      pat = (nxt == P1 || nxt == R1) ? (d ? 2'b01 : 2'b10) :
            nxt == P2 ? 2'b11 :
            nxt == P3 ? (d ? 2'b10 : 2'b01) : 2'b00;
      inc = nxt == DONE && state != DONE && !take_abort && !aborted;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= 8'd0;
         dir_l <= 1'b0;
         aborted <= 1'b0;
         bus.a <= 1'b0;
         bus.b <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         cin <= '0;
         cout <= '0;
      end else begin
         state <= nxt;
         cnt <= nxt != state ? 8'(DWELL - 1) : cnt == 8'd0 ? cnt : cnt - 8'd1;
         {bus.a, bus.b} <= pat;
         bus.busy <= nxt inside {P1, P2, P3, R1};
         bus.done <= nxt == DONE;
         if (state == IDLE && bus.start) dir_l <= bus.dir;
         if (state == IDLE) aborted <= 1'b0;
         else if (take_abort) aborted <= 1'b1;
         if (inc && !dir_l) cin <= cin + CNT_W'(1);
         if (inc && dir_l) cout <= cout + CNT_W'(1);
      end
   end
   assign bus.cars_in = cin;
   assign bus.cars_out = cout;
endmodule

// File: doc/carpark_sensor_gen.md
# carpark_sensor_gen

Car-sensor stimulus generator for the car-park design: the driving end of the `a`/`b` beam-sensor interface consumed by the car-park FSM. On a start request, it emits the correct two-beam occlusion sequence for one car entering or exiting. Each phase holds for a programmable dwell time. It keeps counts of completed entries and exits. It is used in benches and on-board demo builds to exercise the car-park FSM without physical sensors.

## Interface
- `DWELL`, default 4: cycles each sensor phase is held; legal range 1..255.
- `CNT_W`, default 8: width of the entry/exit counters.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request one car event; sampled only in IDLE.
- `dir` in 1: sampled with `start`. 0 = enter, 1 = exit.
- `abort` in 1: present only with `CARPARK_GEN_ABORT_EN`. Car backs out.
- `a` out 1: outer beam blocked (registered).
- `b` out 1: inner beam blocked (registered).
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse at sequence end.
- `cars_in` out CNT_W: completed entries.
- `cars_out` out CNT_W: completed exits.

## Operation
- **States:** IDLE, P1, P2, P3, R1 (reverse phase 1, abort only), DONE.
- **Phase patterns {a,b}:**
  - Enter: P1 = 10, P2 = 11, P3 = 01.
  - Exit: P1 = 01, P2 = 11, P3 = 10.
  - IDLE and DONE: 00.
  - R1 repeats the P1 pattern of the latched direction.
- `dir` is latched on acceptance. Changes to `dir` mid-sequence are ignored.
- A dwell counter loads DWELL−1 on entry to each phase. The phase advances when the counter reaches 0.
- **Transitions:**
  - IDLE→P1 on `start`.
  - P1→P2→P3→DONE on dwell expiry.
  - DONE→IDLE unconditionally after 1 cycle.
  - R1→DONE on dwell expiry.
- **Counters:**
  - `cars_in` increments by 1 on the DONE cycle of a non-aborted enter.
  - `cars_out` increments by 1 on the DONE cycle of a non-aborted exit.
  - Both wrap modulo 2^CNT_W (all-ones+1 = 0) with no flag.
- `start` is ignored while `busy` is high and in the DONE cycle; there is no queueing.
- **Reset (any state, including mid-sequence):** next cycle is IDLE, `a`=`b`=0, `busy`=0, `done`=0, counters=0, dwell counter=0, latched `dir`=0.

## Timing
- Request accepted at edge T (`start`=1 in IDLE).
- Cycles T+1..T+DWELL: P1.
- Cycles T+DWELL+1..T+2·DWELL: P2.
- Cycles T+2·DWELL+1..T+3·DWELL: P3.
- Cycle T+3·DWELL+1: DONE, with `a`=`b`=0, `done`=1, `busy`=0, and the counter showing its new value.
- The earliest next acceptance is edge T+3·DWELL+2. This guarantees at least one 00 cycle between cars.
- `busy`=1 exactly in P1/P2/P3/R1.
- `a`, `b`, `busy` and `done` are all registered, with no combinational path from inputs.

## Configuration
- **`CARPARK_GEN_ABORT_EN` defined:** `abort` port exists.
  - `abort`=1 in P1: next cycle is DONE.
  - `abort`=1 in P2: next cycle is R1 for DWELL cycles, then DONE.
  - `abort` in P3, R1, IDLE or DONE: ignored (car committed or already backing out).
  - An aborted sequence pulses `done` but leaves both counters unchanged.
  - If `abort` and `reset` are high together, reset wins.
- **`CARPARK_GEN_ABORT_EN` undefined:** no `abort` port. Behaviour is identical to `abort` tied 0, and R1 is unreachable or removed.

## Test plan
- **Enter:** DWELL=2, reset, then `start`=1, `dir`=0 for 1 cycle → {a,b} = 10,10,11,11,01,01. Next cycle `done`=1, {a,b}=00, `cars_in`=1, `cars_out`=0.
- **Exit:** `dir`=1 → sequence 01,01,11,11,10,10, then `done` with `cars_out`=1. `start` held high throughout is accepted only once per IDLE entry, so the next sequence begins one cycle after the DONE cycle.
- **Start while busy:** pulse `start` during P2 → no effect. Total sequence length remains 3·DWELL, and exactly one `done`.
- **Wrap:** CNT_W=2, run 5 enters → `cars_in` reads 1,2,3,0,1.
- **Reset mid-sequence:** assert `reset` in P2 → next cycle {a,b}=00, `busy`=0, counters 0. A subsequent `start` produces a full clean sequence.
- **Abort (macro on):** DWELL=2, enter, `abort` on the 1st P2 cycle → 10,10,11,10,10, then `done`=1 with `cars_in` unchanged. `abort` during P3 → full sequence completes and `cars_in` increments.
